// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI master and the SPI slave receiver.
//   spi_state_t - receiver state machine encoding (IDLE, SHIFT)
//   SPI_DATA_W  - default bits per word, shared with the master
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// spi_sync: multi-flop bit synchronizer with a selectable reset value.
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset; every stage loads RESET_VAL
//   d       - asynchronous input bit
//   q       - synchronized output (last stage of the chain)
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule : spi_sync

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: receive-only SPI endpoint, oversampled by the system clock.
// mosi is shifted in MSB first on falling edges of the synchronized spi_clk
// while a frame (cs low) is active; each completed word is offered on a
// valid/ready holding register.
// Ports:
//   clk       - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   spi_clk   - SPI clock from the master, idles high
//   cs        - chip select, active low
//   mosi      - serial data, MSB first
//   rx_data   - last accepted word
//   rx_valid  - rx_data holds an unconsumed word
//   rx_ready  - consumer takes the word when rx_valid && rx_ready
//   busy      - a frame is in progress
//   frame_err - one-cycle pulse: frame ended with a partial word pending
//   overrun   - one-cycle pulse: a word completed while the holder was full
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_clk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int                CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  WORD_BITS = CNT_W'(DATA_W);

    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi_clk),
        .q       (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (cs),
        .q       (cs_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (mosi),
        .q       (mosi_s)
    );

    spi_state_t              state;
    logic                    sclk_d;
    logic                    cs_d;
    logic [SYNC_STAGES-1:0]  warm;
    logic                    armed;
    logic [CNT_W-1:0]        bitcnt;
    logic [DATA_W-1:0]       shreg;

    logic sclk_fall;
    logic cs_fall;
    logic word_done;

    assign sclk_fall = sclk_d & ~sclk_s;
    assign cs_fall   = cs_d & ~cs_s;
    assign word_done = (state == SHIFT) && (bitcnt == WORD_BITS);
    assign busy      = (state == SHIFT);

    // The synchronizers come out of reset reading 1, so a cs held low across
    // reset release would look like a fresh 1->0 edge. 'warm' marks the point
    // where the chains hold real pin samples, and 'armed' only sets once cs
    // has genuinely been seen high after that, so in-progress frames are
    // never joined.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            warm <= {warm[SYNC_STAGES-2:0], 1'b1};
            if (warm[SYNC_STAGES-1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sclk_d    <= 1'b1;
            cs_d      <= 1'b1;
            bitcnt    <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state)
                IDLE: begin
                    bitcnt <= '0;
                    if (cs_fall && armed) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        // A word finishing exactly as cs rises still counts
                        // as complete, so it is not a framing error.
                        state  <= IDLE;
                        bitcnt <= '0;
                        if (bitcnt != '0 && !word_done) begin
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        shreg  <= {shreg[DATA_W-2:0], mosi_s};
                        bitcnt <= word_done ? CNT_W'(1) : bitcnt + CNT_W'(1);
                    end else if (word_done) begin
                        bitcnt <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    bitcnt <= '0;
                end
            endcase

            // Holding register: a full, unread holder keeps its word and the
            // newcomer is dropped.
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule : spi_slave_rx

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed testbench for spi_slave_rx. Drives SPI frames
// bit by bit, collects accepted words and flag pulses with a monitor, and
// compares against hand-computed expected values.
module tb_spi_slave_rx;

    localparam int DATA_W = 8;
    localparam int H      = 6;   // spi_clk half-period in clk cycles

    logic              clk = 1'b0;
    logic              reset_n;
    logic              spi_clk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spi_clk   (spi_clk),
        .cs        (cs),
        .mosi      (mosi),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int                cyc = 0;
    logic [DATA_W-1:0] got_q[$];
    int                n_ferr = 0;
    int                n_ovr = 0;
    int                n_busy_hi = 0;
    int                n_busy_gap = 0;
    int                valid_rise_cyc = -1;
    int                ferr_cyc = -1;
    logic              valid_prev = 1'b0;
    logic              in_frame = 1'b0;
    int                last_fall_cyc = 0;
    int                cs_rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_valid && !valid_prev) valid_rise_cyc = cyc;
            if (frame_err) begin
                n_ferr++;
                ferr_cyc = cyc;
            end
            if (overrun) n_ovr++;
            if (busy) n_busy_hi++;
            if (in_frame && !busy) n_busy_gap++;
        end
        valid_prev = rx_valid;
    end

    function automatic logic [31:0] peek(input int i);
        if (i < got_q.size()) return {24'h0, got_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            wait_cyc(H);
            spi_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(H);
            spi_clk = 1'b1;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_cyc(6);
        in_frame = 1'b1;
    endtask

    task automatic cs_high();
        wait_cyc(H);
        in_frame = 1'b0;
        cs = 1'b1;
        cs_rise_cyc = cyc;
        wait_cyc(20);
    endtask

    int base_ferr, base_ovr, base_busy;

    initial begin
        reset_n  = 1'b0;
        spi_clk  = 1'b1;
        cs       = 1'b1;
        mosi     = 1'b0;
        rx_ready = 1'b1;

        // reset state
        wait_cyc(4);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        reset_n = 1'b1;
        wait_cyc(10);

        // single byte 0xA5
        got_q.delete();
        base_ferr = n_ferr; base_ovr = n_ovr;
        cs_low();
        send_bits(32'hA5, 8);
        cs_high();
        check("a5_count", got_q.size(), 32'd1);
        check("a5_data", peek(0), 32'hA5);
        check("a5_latency", valid_rise_cyc - last_fall_cyc, 32'd4);
        check("a5_ferr", n_ferr - base_ferr, 32'd0);
        check("a5_ovr", n_ovr - base_ovr, 32'd0);

        // two words in one frame
        got_q.delete();
        base_busy = n_busy_gap;
        cs_low();
        send_bits(32'h3C, 8);
        send_bits(32'hC3, 8);
        cs_high();
        check("two_count", got_q.size(), 32'd2);
        check("two_w0", peek(0), 32'h3C);
        check("two_w1", peek(1), 32'hC3);
        check("two_busy_gap", n_busy_gap - base_busy, 32'd0);

        // overrun with rx_ready low
        got_q.delete();
        rx_ready = 1'b0;
        base_ovr = n_ovr; base_ferr = n_ferr;
        cs_low();
        send_bits(32'h11, 8);
        send_bits(32'h22, 8);
        cs_high();
        check("ovr_valid", {31'h0, rx_valid}, 32'h1);
        check("ovr_data", {24'h0, rx_data}, 32'h11);
        check("ovr_pulses", n_ovr - base_ovr, 32'd1);
        check("ovr_ferr", n_ferr - base_ferr, 32'd0);
        rx_ready = 1'b1;
        wait_cyc(1);
        check("ovr_clear", {31'h0, rx_valid}, 32'h0);
        check("ovr_taken", peek(0), 32'h11);
        check("ovr_taken_cnt", got_q.size(), 32'd1);
        wait_cyc(5);

        // partial frame of 5 bits, then a clean 0x5A
        got_q.delete();
        base_ferr = n_ferr;
        cs_low();
        send_bits(32'h16, 5);
        cs_high();
        check("part_ferr", n_ferr - base_ferr, 32'd1);
        check("part_ferr_lat", ferr_cyc - cs_rise_cyc, 32'd3);
        check("part_no_word", got_q.size(), 32'd0);
        cs_low();
        send_bits(32'h5A, 8);
        cs_high();
        check("after_part_cnt", got_q.size(), 32'd1);
        check("after_part_data", peek(0), 32'h5A);
        check("after_part_ferr", n_ferr - base_ferr, 32'd1);

        // reset in the middle of a frame
        got_q.delete();
        cs_low();
        send_bits(32'h5, 3);
        check("mid_busy_before", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_data", {24'h0, rx_data}, 32'h0);
        check("mid_rst_valid", {31'h0, rx_valid}, 32'h0);
        in_frame = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        base_busy = n_busy_hi; base_ferr = n_ferr;
        send_bits(32'h1F, 5);
        cs_high();
        check("mid_ignored_busy", n_busy_hi - base_busy, 32'd0);
        check("mid_ignored_word", got_q.size(), 32'd0);
        check("mid_ignored_ferr", n_ferr - base_ferr, 32'd0);
        cs_low();
        send_bits(32'hFF, 8);
        cs_high();
        check("post_rst_cnt", got_q.size(), 32'd1);
        check("post_rst_data", peek(0), 32'hFF);

        // spi_clk toggling with cs high
        got_q.delete();
        base_busy = n_busy_hi; base_ferr = n_ferr; base_ovr = n_ovr;
        for (int i = 0; i < 16; i++) begin
            mosi = i[0];
            spi_clk = ~spi_clk;
            wait_cyc(H);
        end
        wait_cyc(20);
        check("idle_clk_word", got_q.size(), 32'd0);
        check("idle_clk_busy", n_busy_hi - base_busy, 32'd0);
        check("idle_clk_ferr", n_ferr - base_ferr, 32'd0);
        check("idle_clk_ovr", n_ovr - base_ovr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_spi_slave_rx
